// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter in front of a single 8N1 UART transmitter.
// One requester is granted per frame; grants happen only while the line is idle.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               sck,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  output logic [N_REQ-1:0]   ack,
  output logic               tx,
  output logic               busy,
  output logic [2:0]         src
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [PW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] ack_d;
  logic             tx_d, busy_d;
  logic [2:0]       src_d;

  logic             found;
  logic [PW-1:0]    win;
  logic [7:0]       win_byte;
  int               cand;

  // Search starts one past the last grant and wraps; first asserted request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req[PW'(cand)]) begin
        found = 1'b1;
        win   = PW'(cand);
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == PW'(i)) win_byte = data[8*i +: 8];
    end
  end

  wire baud_done = (baud_q == BW'(CLKS_PER_BIT - 1));

  // Next-state and next-output logic; every register holds unless changed below.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    ack_d   = '0;
    tx_d    = tx;
    busy_d  = busy;
    src_d   = src;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (found) begin
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          ack_d   = N_REQ'(1) << win;
          src_d   = 3'(win);
          last_d  = win;
          shreg_d = win_byte;
        end
      end
      START: begin
        if (baud_done) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          state_d = IDLE;
          baud_d  = '0;
          busy_d  = 1'b0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sck or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      last_q  <= PW'(N_REQ - 1);
      ack     <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      src     <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      ack     <= ack_d;
      tx      <= tx_d;
      busy    <= busy_d;
      src     <= src_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with N_REQ=4, CLKS_PER_BIT=4.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int CPB = 4;

  logic           sck = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic [N-1:0]   ack;
  logic           tx;
  logic           busy;
  logic [2:0]     src;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.N_REQ(N), .CLKS_PER_BIT(CPB)) dut (
    .sck(sck), .reset(reset), .req(req), .data(data),
    .ack(ack), .tx(tx), .busy(busy), .src(src)
  );

  always #5 sck = ~sck;

  task automatic tick(input int n);
    repeat (n) @(negedge sck);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until an ack is seen; n is the number of cycles it took.
  task automatic wait_ack(output int n);
    n = 0;
    while (ack == '0 && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  // Starts on the sample right after the grant edge; ends with the line idle again.
  task automatic frame(input logic [7:0] b, input logic [3:0] exp_ack, input int who);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int c = 0; c < 10*CPB; c++) begin
      chk("frame_tx", 32'(tx), 32'(bits[0]));
      chk("frame_busy", 32'(busy), 32'd1);
      chk("frame_ack", 32'(ack), (c == 0) ? 32'(exp_ack) : 32'd0);
      chk("frame_src", 32'(src), 32'(who));
      if (c % CPB == CPB - 1) bits = bits >> 1;
      tick(1);
    end
    chk("end_tx", 32'(tx), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_ack", 32'(ack), 32'd0);
  endtask

  initial begin
    int n;
    logic [3:0] grant_mask;
    reset = 1'b0;
    req   = '0;
    data  = '0;
    tick(3);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_src", 32'(src), 32'd0);
    reset = 1'b1;
    tick(1);
    chk("idle_noreq_ack", 32'(ack), 32'd0);
    chk("idle_noreq_busy", 32'(busy), 32'd0);

    // Single frame from requester 0, 0xA5.
    req = 4'b0001;
    data[7:0] = 8'hA5;
    wait_ack(n);
    chk("a5_latency", 32'(n), 32'd1);
    req = 4'b0000;
    frame(8'hA5, 4'b0001, 0);

    // Fresh reset, then all four requesting: order 0,1,2,3, 41 cycles apart.
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      wait_ack(n);
      chk("rr_gap", 32'(n), 32'd1);
      grant_mask = 4'(1 << g);
      chk("rr_ack", 32'(ack), 32'(grant_mask));
      req = req & ~grant_mask;
      frame(8'(8'h11 * (g + 1)), grant_mask, g);
    end

    // Requesters 1 and 2 held continuously must alternate.
    req = 4'b0110;
    for (int g = 0; g < 4; g++) begin
      wait_ack(n);
      chk("alt_gap", 32'(n), 32'd1);
      chk("alt_src", 32'(src), (g % 2 == 0) ? 32'd1 : 32'd2);
      frame((g % 2 == 0) ? 8'h22 : 8'h33, (g % 2 == 0) ? 4'b0010 : 4'b0100, (g % 2 == 0) ? 1 : 2);
    end
    req = 4'b0000;

    // Requester 3 pulses mid-frame and drops before the line is idle: never served.
    req = 4'b0001;
    data[7:0] = 8'h5A;
    wait_ack(n);
    chk("pulse_grant", 32'(ack), 32'b0001);
    req = 4'b0000;
    for (int c = 0; c < 45; c++) begin
      if (c == 10) req = 4'b1000;
      if (c == 15) req = 4'b0000;
      chk("pulse_ack", 32'(ack), (c == 0) ? 32'b0001 : 32'd0);
      chk("pulse_src", 32'(src), 32'd0);
      if (c >= 40) begin
        chk("pulse_tx_idle", 32'(tx), 32'd1);
        chk("pulse_busy_idle", 32'(busy), 32'd0);
      end
      tick(1);
    end

    // Data changed right after the ack must not alter the byte on the line.
    req = 4'b0001;
    data[7:0] = 8'h3C;
    wait_ack(n);
    req = 4'b0000;
    data[7:0] = 8'hFF;
    frame(8'h3C, 4'b0001, 0);

    // Reset during DATA bit 3 of a frame from requester 3.
    req = 4'b1000;
    data[31:24] = 8'hF7;
    wait_ack(n);
    chk("abort_src", 32'(src), 32'd3);
    req = 4'b0000;
    tick(4 + 3*CPB + 1);
    chk("abort_bit3_tx", 32'(tx), 32'd0);
    chk("abort_bit3_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_src_rst", 32'(src), 32'd0);
    tick(2);
    chk("abort_ack", 32'(ack), 32'd0);
    req = 4'b1001;
    data[7:0] = 8'h81;
    reset = 1'b1;
    tick(1);
    chk("post_rst_ack", 32'(ack), 32'b0001);
    req = 4'b1000;
    frame(8'h81, 4'b0001, 0);
    tick(1);
    chk("post_rst_next_ack", 32'(ack), 32'b1000);
    chk("post_rst_next_src", 32'(src), 32'd3);
    req = 4'b0000;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the transmitter (2..8).
REQ-002 Parameter CLKS_PER_BIT, default 16: sck cycles per serial bit (minimum 2).
REQ-003 sck  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-005 req  input  N_REQ  per-requester transmit request, level; held until the matching ack.
REQ-006 data  input  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 ack  output  N_REQ  one-hot, one-cycle pulse; the byte from that requester was accepted.
REQ-008 tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-009 busy  output  1  high while a frame (start, data or stop bit) is on tx.
REQ-010 src  output  3  index of the requester whose frame is in progress or was last sent.

Function
REQ-011 FSM states: IDLE, START, DATA, STOP; tx and busy are driven from registers, with no combinational path from inputs.
REQ-012 IDLE: tx=1, busy=0; arbitration occurs only in IDLE.
REQ-013 IDLE with any req bit high at edge E: winner i latched into src, data[8i+7:8i] latched into the shift register, state -> START, tx -> 0, busy -> 1, ack[i] -> 1 for exactly the cycle after E.
REQ-014 IDLE with req all zero: remain in IDLE, with no ack.
REQ-015 Round-robin: search starts at (last granted index + 1) mod N_REQ and wraps; the first asserted req wins.
REQ-016 After reset, the last-granted pointer = N_REQ-1, so requester 0 has highest priority first.
REQ-017 START holds tx=0 for CLKS_PER_BIT cycles, then goes to DATA.
REQ-018 DATA sends bits 0..7, each held CLKS_PER_BIT cycles; the bit counter is 3 bits and the exit condition is bit 7 completing (no overflow bit used).
REQ-019 STOP holds tx=1 for CLKS_PER_BIT cycles, then goes to IDLE with busy -> 0.
REQ-020 Frame length is exactly 10*CLKS_PER_BIT cycles from START entry to IDLE entry; back-to-back frames are separated by exactly one IDLE cycle (period 10*CLKS_PER_BIT+1).
REQ-021 The baud counter runs from 0 to CLKS_PER_BIT-1, is cleared on every state change, and is held at 0 in IDLE.
REQ-022 req changes during START/DATA/STOP do not affect the current frame; a req dropped before the next IDLE is never served and never acked.
REQ-023 A data change after the ack edge does not affect the transmitted byte.
REQ-024 Requests from all N_REQ requesters held continuously produce a grant order that cycles 0,1,..,N_REQ-1,0,... with no requester starved.
REQ-025 src changes only on a grant edge.

Reset
REQ-026 reset=0 forces, asynchronously: state IDLE, tx=1, busy=0, ack=0, src=0, shift register 0, counters 0, and last-granted pointer N_REQ-1.
REQ-027 reset asserted mid-frame aborts the frame immediately (tx=1), and the aborted requester receives no further ack.
REQ-028 The first grant may occur on the first sck edge after reset deasserts.

Verification (CLKS_PER_BIT=4, N_REQ=4)
REQ-029 req=0001, data0=0xA5 -> ack=0001 for one cycle; tx=0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high for 40 cycles; src=0.
REQ-030 req=1111 held, with acked bits dropped -> grants in order 0,1,2,3, each frame 41 cycles apart.
REQ-031 req1 and req2 held continuously -> grants alternate 1,2,1,2; no requester is granted twice in a row.
REQ-032 reset=0 asserted in DATA bit 3 -> tx=1 and busy=0 in the same cycle; after release with req=1001 -> requester 0 is granted first.
REQ-033 req3 pulsed for 5 cycles during a busy frame and dropped before STOP ends -> no ack[3], and tx stays 1 after the frame.
REQ-034 data0 changed from 0x3C to 0xFF one cycle after ack -> 0x3C is transmitted on tx.
